// File: rtl/pkt_af_gate.sv
// pkt_af_gate: Avalon-ST packet gate in front of a downstream packet FIFO.
// Decides at each SOP, from almost_full, whether a whole packet is forwarded
// or dropped (DROP_MODE=1) or whether the SOP is held back (DROP_MODE=0).
// Forwarded beats are registered and appear one cycle after acceptance.
// Optional statistics counters are enabled by defining PKT_AF_GATE_STATS_EN.
module pkt_af_gate #(
    parameter int DATA_W    = 512,
    parameter int EMPTY_W   = 6,
    parameter int DROP_MODE = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_startofpacket,
    input  logic               in_endofpacket,
    input  logic [EMPTY_W-1:0] in_empty,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
    output logic [EMPTY_W-1:0] out_empty,
    input  logic               almost_full,
    output logic [31:0]        pkt_cnt,
    output logic [31:0]        drop_cnt,
    output logic [31:0]        err_cnt,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   fwd;
    logic   inc_pkt, inc_drop, inc_err;

    // Backpressure: stall mode holds off an SOP in IDLE while the FIFO is almost full
    always_comb begin
        in_ready = reset_n;
        if (DROP_MODE == 0 && state == IDLE && almost_full)
            in_ready = 1'b0;
    end

    assign accept = in_valid && in_ready;
    assign busy   = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state, forward decision and counter strobes for the accepted beat
    always_comb begin
        state_nxt = state;
        fwd       = 1'b0;
        inc_pkt   = 1'b0;
        inc_drop  = 1'b0;
        inc_err   = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (in_startofpacket) begin
                        if (!almost_full) begin
                            fwd = 1'b1;
                            if (in_endofpacket)
                                inc_pkt = 1'b1;
                            else
                                state_nxt = PASS;
                        end else begin
                            inc_drop = 1'b1;
                            if (!in_endofpacket)
                                state_nxt = DROP;
                        end
                    end else begin
                        inc_err = 1'b1;
                    end
                end
                PASS: begin
                    fwd = 1'b1;
                    if (in_startofpacket)
                        inc_err = 1'b1;
                    if (in_endofpacket) begin
                        inc_pkt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                DROP: begin
                    if (in_startofpacket)
                        inc_err = 1'b1;
                    if (in_endofpacket)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output register: forwarded beat appears one cycle after acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid         <= 1'b0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_data          <= '0;
            out_empty         <= '0;
        end else begin
            out_valid         <= fwd;
            out_startofpacket <= fwd && in_startofpacket;
            out_endofpacket   <= fwd && in_endofpacket;
            if (fwd) begin
                out_data  <= in_data;
                out_empty <= in_empty;
            end
        end
    end

`ifdef PKT_AF_GATE_STATS_EN
    logic [31:0] pkt_q, drop_q, err_q;

    // Saturating statistics counters; each one updates independently
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_q  <= '0;
            drop_q <= '0;
            err_q  <= '0;
        end else begin
            if (inc_pkt && pkt_q != '1)
                pkt_q <= pkt_q + 32'd1;
            if (inc_drop && drop_q != '1)
                drop_q <= drop_q + 32'd1;
            if (inc_err && err_q != '1)
                err_q <= err_q + 32'd1;
        end
    end

    assign pkt_cnt  = pkt_q;
    assign drop_cnt = drop_q;
    assign err_cnt  = err_q;
`else
    logic unused_inc;
    assign unused_inc = ^{inc_pkt, inc_drop, inc_err};
    assign pkt_cnt    = '0;
    assign drop_cnt   = '0;
    assign err_cnt    = '0;
`endif

endmodule
